// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and oversampling tick positions.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;
  localparam int LAST_TICK  = 15;

endpackage

// File: rtl/uart_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; RESET_VAL sets the
// value both flops take in reset (1 for an idle-high serial line).
module uart_sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_p0;
  logic sync_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_p0 <= RESET_VAL;
      sync_p1 <= RESET_VAL;
    end else begin
      meta_p0 <= d;
      sync_p1 <= meta_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/uart_rx.sv
// UART receiver driven by a 16x oversampling strobe; samples each bit mid-period.
// Define UART_RX_PARITY_EN to add a parity bit and the parity_err output.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] rx_dout,
  output logic            rx_done_tick,
  output logic            frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic            parity_err
`endif
);

  localparam int SW = $clog2(SB_TICK);
  localparam int NW = $clog2(DBIT);

  localparam logic [SW-1:0] S_MID      = SW'(MID_SAMPLE);
  localparam logic [SW-1:0] S_LAST     = SW'(LAST_TICK);
  localparam logic [SW-1:0] S_STOP_END = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST     = NW'(DBIT - 1);

  if (DBIT < 5 || DBIT > 9 || SB_TICK < OVERSAMPLE ||
      (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_param
    $error("uart_rx: illegal parameter combination");
  end

  rx_state_t       state_reg, state_next;
  logic [SW-1:0]   s_reg, s_next;
  logic [NW-1:0]   n_reg, n_next;
  logic [DBIT-1:0] shift_reg, shift_next;
  logic [DBIT-1:0] dout_reg, dout_next;
  logic            done_reg, done_next;
  logic            ferr_reg, ferr_next;
  logic            stop_ok_reg, stop_ok_next;
  logic            rx_s;

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_ODD = (PARITY_ODD != 0);
  logic par_reg, par_next;
  logic perr_reg, perr_next;
`endif

  uart_sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      s_reg       <= '0;
      n_reg       <= '0;
      shift_reg   <= '0;
      dout_reg    <= '0;
      done_reg    <= 1'b0;
      ferr_reg    <= 1'b0;
      stop_ok_reg <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_reg     <= 1'b0;
      perr_reg    <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      s_reg       <= s_next;
      n_reg       <= n_next;
      shift_reg   <= shift_next;
      dout_reg    <= dout_next;
      done_reg    <= done_next;
      ferr_reg    <= ferr_next;
      stop_ok_reg <= stop_ok_next;
`ifdef UART_RX_PARITY_EN
      par_reg     <= par_next;
      perr_reg    <= perr_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    s_next       = s_reg;
    n_next       = n_reg;
    shift_next   = shift_reg;
    dout_next    = dout_reg;
    done_next    = 1'b0;
    ferr_next    = ferr_reg;
    stop_ok_next = stop_ok_reg;
`ifdef UART_RX_PARITY_EN
    par_next     = par_reg;
    perr_next    = perr_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          s_next     = '0;
        end
      end
      START: begin
        // A start bit that is gone by its mid-point is treated as line noise.
        if (s_tick) begin
          if (s_reg == S_MID) begin
            if (!rx_s) begin
              state_next = DATA;
              s_next     = '0;
              n_next     = '0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            s_next = s_reg + SW'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_reg == S_LAST) begin
            s_next     = '0;
            shift_next = {rx_s, shift_reg[DBIT-1:1]};
            if (n_reg == N_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_next = PARITY;
`else
              state_next = STOP;
`endif
            end else begin
              n_next = n_reg + NW'(1);
            end
          end else begin
            s_next = s_reg + SW'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (s_reg == S_LAST) begin
            s_next     = '0;
            par_next   = rx_s;
            state_next = STOP;
          end else begin
            s_next = s_reg + SW'(1);
          end
        end
      end
`endif
      STOP: begin
        // With one stop bit the mid-point and the end coincide, so the live
        // sample is used instead of the latched one.
        if (s_tick) begin
          if (s_reg == S_LAST) begin
            stop_ok_next = rx_s;
          end
          if (s_reg == S_STOP_END) begin
            state_next = IDLE;
            done_next  = 1'b1;
            dout_next  = shift_reg;
            ferr_next  = ~((s_reg == S_LAST) ? rx_s : stop_ok_reg);
`ifdef UART_RX_PARITY_EN
            perr_next  = (^shift_reg) ^ par_reg ^ PAR_ODD;
`endif
          end else begin
            s_next = s_reg + SW'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign rx_dout      = dout_reg;
  assign rx_done_tick = done_reg;
  assign frame_err    = ferr_reg;
`ifdef UART_RX_PARITY_EN
  assign parity_err   = perr_reg;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx (8 data bits, one stop bit);
// also covers parity when compiled with UART_RX_PARITY_EN.
module tb_uart_rx;

`ifdef UART_RX_PARITY_EN
  localparam int         FRAME_TICKS = 176;
  localparam logic [7:0] BREAK_TAIL  = 8'hFE;
`else
  localparam int         FRAME_TICKS = 160;
  localparam logic [7:0] BREAK_TAIL  = 8'hFC;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_dout;
  logic       rx_done_tick;
  logic       frame_err;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  uart_rx #(
    .DBIT       (8),
    .SB_TICK    (16),
    .PARITY_ODD (0)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .rx           (rx),
    .rx_dout      (rx_dout),
    .rx_done_tick (rx_done_tick),
    .frame_err    (frame_err)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err   (parity_err)
`endif
  );

  always #5 clk = ~clk;

  int tick_div = 54;
  int div_cnt  = 0;
  always @(negedge clk) begin
    if (div_cnt >= tick_div - 1) begin
      div_cnt <= 0;
      s_tick  <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 1;
      s_tick  <= 1'b0;
    end
  end

  int         tick_cnt = 0;
  int         done_cnt = 0;
  int         pulse_tick = 0;
  int         prev_pulse_tick = 0;
  logic [7:0] last_dout = 8'h00;
  logic [7:0] prev_dout = 8'h00;
  logic       last_ferr = 1'b0;
  logic       prev_ferr = 1'b0;

  always @(posedge clk) begin
    if (s_tick) tick_cnt <= tick_cnt + 1;
  end

  always @(negedge clk) begin
    if (rx_done_tick === 1'b1) begin
      done_cnt        <= done_cnt + 1;
      prev_pulse_tick <= pulse_tick;
      pulse_tick      <= tick_cnt;
      prev_dout       <= last_dout;
      last_dout       <= rx_dout;
      prev_ferr       <= last_ferr;
      last_ferr       <= frame_err;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (s_tick !== 1'b1) @(posedge clk);
    end
  endtask

  task automatic send_bit(input logic b, input int n);
    @(negedge clk);
    rx = b;
    wait_ticks(n);
  endtask

  task automatic send_data(input logic [7:0] data);
    for (int i = 0; i < 8; i++) send_bit(data[i], 16);
  endtask

  // stop_low > 0 drives the stop bit low for that many ticks, then idles high.
  task automatic send_frame(input logic [7:0] data, input int stop_low);
    send_bit(1'b0, 16);
    send_data(data);
`ifdef UART_RX_PARITY_EN
    send_bit(^data, 16);
`endif
    if (stop_low > 0) begin
      send_bit(1'b0, stop_low);
      send_bit(1'b1, 32 - stop_low);
    end else begin
      send_bit(1'b1, 16);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx    = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    if (rx_dout !== 8'h00) begin
      n_fail++; $display("FAIL reset_dout: got %h expected 00", rx_dout);
    end
    n_checks++;
    if (rx_done_tick !== 1'b0) begin
      n_fail++; $display("FAIL reset_done: got %b expected 0", rx_done_tick);
    end
    n_checks++;
    if (frame_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_ferr: got %b expected 0", frame_err);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_basic();
    int base;
    base = done_cnt;
    send_bit(1'b1, 4);
    send_frame(8'h55, 0);
    n_checks++;
    if (done_cnt !== base + 1) begin
      n_fail++; $display("FAIL basic_pulses: got %0d expected %0d", done_cnt - base, 1);
    end
    n_checks++;
    if (last_dout !== 8'h55) begin
      n_fail++; $display("FAIL basic_dout: got %h expected 55", last_dout);
    end
    n_checks++;
    if (last_ferr !== 1'b0) begin
      n_fail++; $display("FAIL basic_ferr: got %b expected 0", last_ferr);
    end
    n_checks++;
    if (rx_dout !== 8'h55 || rx_done_tick !== 1'b0) begin
      n_fail++; $display("FAIL basic_hold: got dout %h done %b expected 55 0", rx_dout, rx_done_tick);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    base = done_cnt;
    send_frame(8'hA3, 0);
    send_frame(8'h0F, 0);
    n_checks++;
    if (done_cnt !== base + 2) begin
      n_fail++; $display("FAIL b2b_pulses: got %0d expected 2", done_cnt - base);
    end
    n_checks++;
    if (prev_dout !== 8'hA3) begin
      n_fail++; $display("FAIL b2b_first: got %h expected a3", prev_dout);
    end
    n_checks++;
    if (last_dout !== 8'h0F) begin
      n_fail++; $display("FAIL b2b_second: got %h expected 0f", last_dout);
    end
    n_checks++;
    if (pulse_tick - prev_pulse_tick !== FRAME_TICKS) begin
      n_fail++; $display("FAIL b2b_spacing: got %0d ticks expected %0d", pulse_tick - prev_pulse_tick, FRAME_TICKS);
    end
  endtask

  task automatic test_glitch();
    int         base;
    logic [7:0] dsave;
    base  = done_cnt;
    dsave = rx_dout;
    send_bit(1'b0, 4);
    send_bit(1'b1, 180);
    n_checks++;
    if (done_cnt !== base) begin
      n_fail++; $display("FAIL glitch_pulses: got %0d expected 0", done_cnt - base);
    end
    n_checks++;
    if (rx_dout !== dsave) begin
      n_fail++; $display("FAIL glitch_dout: got %h expected %h", rx_dout, dsave);
    end
  endtask

  task automatic test_frame_err();
    int base;
    base = done_cnt;
    send_frame(8'hFF, 10);
    n_checks++;
    if (done_cnt !== base + 1 || last_dout !== 8'hFF) begin
      n_fail++; $display("FAIL ferr_frame: got %0d pulses dout %h expected 1 ff", done_cnt - base, last_dout);
    end
    n_checks++;
    if (last_ferr !== 1'b1 || frame_err !== 1'b1) begin
      n_fail++; $display("FAIL ferr_flag: got %b/%b expected 1", last_ferr, frame_err);
    end
    send_bit(1'b1, 16);
    send_frame(8'h12, 0);
    n_checks++;
    if (done_cnt !== base + 2 || last_dout !== 8'h12) begin
      n_fail++; $display("FAIL ferr_recover: got %0d pulses dout %h expected 2 12", done_cnt - base, last_dout);
    end
    n_checks++;
    if (frame_err !== 1'b0) begin
      n_fail++; $display("FAIL ferr_clear: got %b expected 0", frame_err);
    end
  endtask

  task automatic test_break();
    int base;
    base = done_cnt;
    send_bit(1'b0, 200);
    send_bit(1'b1, 180);
    n_checks++;
    if (done_cnt !== base + 2) begin
      n_fail++; $display("FAIL break_pulses: got %0d expected 2", done_cnt - base);
    end
    n_checks++;
    if (prev_dout !== 8'h00 || prev_ferr !== 1'b1) begin
      n_fail++; $display("FAIL break_frame: got dout %h ferr %b expected 00 1", prev_dout, prev_ferr);
    end
    n_checks++;
    if (last_dout !== BREAK_TAIL || last_ferr !== 1'b0) begin
      n_fail++; $display("FAIL break_tail: got dout %h ferr %b expected %h 0", last_dout, last_ferr, BREAK_TAIL);
    end
  endtask

  task automatic test_reset_mid_frame();
    int base;
    base = done_cnt;
    send_bit(1'b0, 16);
    send_bit(1'b0, 16);
    send_bit(1'b0, 16);
    send_bit(1'b1, 16);
    send_bit(1'b1, 8);
    @(negedge clk);
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (rx_dout !== 8'h00 || frame_err !== 1'b0 || rx_done_tick !== 1'b0) begin
      n_fail++; $display("FAIL midrst_outputs: got dout %h ferr %b done %b expected 00 0 0", rx_dout, frame_err, rx_done_tick);
    end
`ifdef UART_RX_PARITY_EN
    n_checks++;
    if (parity_err !== 1'b0) begin
      n_fail++; $display("FAIL midrst_perr: got %b expected 0", parity_err);
    end
`endif
    reset = 1'b0;
    send_bit(1'b1, 180);
    n_checks++;
    if (done_cnt !== base) begin
      n_fail++; $display("FAIL midrst_pulses: got %0d expected 0", done_cnt - base);
    end
    send_frame(8'h3C, 0);
    n_checks++;
    if (done_cnt !== base + 1 || last_dout !== 8'h3C || last_ferr !== 1'b0) begin
      n_fail++; $display("FAIL midrst_resend: got %0d pulses dout %h ferr %b expected 1 3c 0", done_cnt - base, last_dout, last_ferr);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int base;
    base = done_cnt;
    send_bit(1'b0, 16);
    send_data(8'h07);
    send_bit(1'b1, 16);
    send_bit(1'b1, 16);
    @(negedge clk);
    n_checks++;
    if (done_cnt !== base + 1 || rx_dout !== 8'h07) begin
      n_fail++; $display("FAIL par_good_frame: got %0d pulses dout %h expected 1 07", done_cnt - base, rx_dout);
    end
    n_checks++;
    if (parity_err !== 1'b0) begin
      n_fail++; $display("FAIL par_good_flag: got %b expected 0", parity_err);
    end
    send_bit(1'b0, 16);
    send_data(8'h07);
    send_bit(1'b0, 16);
    send_bit(1'b1, 16);
    @(negedge clk);
    n_checks++;
    if (done_cnt !== base + 2 || rx_dout !== 8'h07) begin
      n_fail++; $display("FAIL par_bad_frame: got %0d pulses dout %h expected 2 07", done_cnt - base, rx_dout);
    end
    n_checks++;
    if (parity_err !== 1'b1) begin
      n_fail++; $display("FAIL par_bad_flag: got %b expected 1", parity_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    @(negedge clk);
    tick_div = 10;
    send_bit(1'b1, 4);
    test_glitch();
    test_frame_err();
    test_break();
    test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
